register_bank_ctrl: RTL and testbench

//  Two-port arbiter and sequencer in front of the 8x8 register bank (R0-R7).
//  Two requesters (0: execute unit, 1: debug/aux) issue READ/WRITE/SWAP ops.

---
 rtl/register_bank_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_register_bank_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_ctrl.sv
// Round-robin arbiter and op sequencer for two requesters in front of the 8x8 register bank.
// Optional feature: define REGBANK_CLEAR_EN to make op 2'b11 a CLEAR; otherwise it completes with rsp_err.
module register_bank_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [1:0]            req0_op,
  input  logic [ADDR_WIDTH-1:0] req0_addr_a,
  input  logic [ADDR_WIDTH-1:0] req0_addr_b,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [1:0]            req1_op,
  input  logic [ADDR_WIDTH-1:0] req1_addr_a,
  input  logic [ADDR_WIDTH-1:0] req1_addr_b,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  bank_write_data,
  output logic                  bank_read_data,
  output logic [ADDR_WIDTH-1:0] bank_in_select,
  output logic [ADDR_WIDTH-1:0] bank_out_select,
  output logic [DATA_WIDTH-1:0] bank_in_data,
  input  logic [DATA_WIDTH-1:0] bank_out_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_SW1,
    ST_SW2,
    ST_SW3,
    ST_CLR,
    ST_ERR
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;

  state_t                r_state;
  state_t                w_nextState;
  logic [1:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addrA;
  logic [ADDR_WIDTH-1:0] r_addrB;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_id;
  logic                  r_lastGrant;
  logic [DATA_WIDTH-1:0] r_tmp;
  logic                  r_rspValid;
  logic                  r_rspId;
  logic [DATA_WIDTH-1:0] r_rspData;
  logic                  r_rspErr;

  logic                  w_grantValid;
  logic                  w_grantId;
  logic                  w_accept;
  logic [1:0]            w_selOp;
  logic [ADDR_WIDTH-1:0] w_selAddrA;
  logic [ADDR_WIDTH-1:0] w_selAddrB;
  logic [DATA_WIDTH-1:0] w_selWdata;

  // On a tie the requester that did not win last time is granted, so neither side starves.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantId    = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grantValid = 1'b1;
      w_grantId    = ~r_lastGrant;
    end else if (req0_valid) begin
      w_grantValid = 1'b1;
      w_grantId    = 1'b0;
    end else if (req1_valid) begin
      w_grantValid = 1'b1;
      w_grantId    = 1'b1;
    end
  end

  assign w_accept   = reset && (r_state == ST_IDLE) && w_grantValid;
  assign req0_ready = w_accept && !w_grantId;
  assign req1_ready = w_accept && w_grantId;

  assign w_selOp    = w_grantId ? req1_op     : req0_op;
  assign w_selAddrA = w_grantId ? req1_addr_a : req0_addr_a;
  assign w_selAddrB = w_grantId ? req1_addr_b : req0_addr_b;
  assign w_selWdata = w_grantId ? req1_wdata  : req0_wdata;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_selOp)
            OP_READ:  w_nextState = ST_RD;
            OP_WRITE: w_nextState = ST_WR;
            OP_SWAP:  w_nextState = ST_SW1;
`ifdef REGBANK_CLEAR_EN
            default:  w_nextState = ST_CLR;
`else
            default:  w_nextState = ST_ERR;
`endif
          endcase
        end
      end
      ST_SW1:  w_nextState = ST_SW2;
      ST_SW2:  w_nextState = ST_SW3;
      ST_RD, ST_WR, ST_SW3, ST_CLR, ST_ERR: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Strobes are gated by reset so an abort suppresses the bank access in the same cycle.
  always_comb begin
    bank_write_data = 1'b0;
    bank_read_data  = 1'b0;
    bank_in_select  = '0;
    bank_out_select = '0;
    bank_in_data    = '0;
    if (reset) begin
      case (r_state)
        ST_RD: begin
          bank_read_data  = 1'b1;
          bank_out_select = r_addrA;
        end
        ST_WR: begin
          bank_write_data = 1'b1;
          bank_in_select  = r_addrA;
          bank_in_data    = r_wdata;
        end
        ST_SW1: begin
          bank_read_data  = 1'b1;
          bank_out_select = r_addrA;
        end
        ST_SW2: begin
          bank_read_data  = 1'b1;
          bank_out_select = r_addrB;
          bank_write_data = 1'b1;
          bank_in_select  = r_addrA;
          bank_in_data    = bank_out_data;
        end
        ST_SW3: begin
          bank_write_data = 1'b1;
          bank_in_select  = r_addrB;
          bank_in_data    = r_tmp;
        end
`ifdef REGBANK_CLEAR_EN
        ST_CLR: begin
          bank_write_data = 1'b1;
          bank_in_select  = r_addrA;
          bank_in_data    = '0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Request latch, swap temporary and registered response; rsp_valid is a single-cycle pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_op        <= '0;
      r_addrA     <= '0;
      r_addrB     <= '0;
      r_wdata     <= '0;
      r_id        <= 1'b0;
      r_lastGrant <= 1'b1;
      r_tmp       <= '0;
      r_rspValid  <= 1'b0;
      r_rspId     <= 1'b0;
      r_rspData   <= '0;
      r_rspErr    <= 1'b0;
    end else begin
      r_rspValid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op        <= w_selOp;
            r_addrA     <= w_selAddrA;
            r_addrB     <= w_selAddrB;
            r_wdata     <= w_selWdata;
            r_id        <= w_grantId;
            r_lastGrant <= w_grantId;
          end
        end
        ST_RD: begin
          r_rspValid <= 1'b1;
          r_rspId    <= r_id;
          r_rspData  <= bank_out_data;
          r_rspErr   <= 1'b0;
        end
        ST_WR: begin
          r_rspValid <= 1'b1;
          r_rspId    <= r_id;
          r_rspData  <= r_wdata;
          r_rspErr   <= 1'b0;
        end
        ST_SW1: begin
          r_tmp <= bank_out_data;
        end
        ST_SW3: begin
          r_rspValid <= 1'b1;
          r_rspId    <= r_id;
          r_rspData  <= r_tmp;
          r_rspErr   <= 1'b0;
        end
        ST_CLR: begin
          r_rspValid <= 1'b1;
          r_rspId    <= r_id;
          r_rspData  <= '0;
          r_rspErr   <= 1'b0;
        end
        ST_ERR: begin
          r_rspValid <= 1'b1;
          r_rspId    <= r_id;
          r_rspData  <= '0;
          r_rspErr   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_rspId;
  assign rsp_data  = r_rspData;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_register_bank_ctrl.sv
// Scoreboard bench for register_bank_ctrl with a behavioural 8x8 bank attached.
// Expected CLEAR behaviour follows whether REGBANK_CLEAR_EN is defined for the build.
module tb_register_bank_ctrl;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
`ifdef REGBANK_CLEAR_EN
  localparam logic CLEAR_ERR = 1'b0;
`else
  localparam logic CLEAR_ERR = 1'b1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [2:0] req0_addr_a, req0_addr_b, req1_addr_a, req1_addr_b;
  logic [7:0] req0_wdata, req1_wdata;
  logic       rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_data;
  logic       bank_write_data, bank_read_data;
  logic [2:0] bank_in_select, bank_out_select;
  logic [7:0] bank_in_data, bank_out_data;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  rsp_t       expQ[$];
  int         assertCount = 0;
  int         failCount = 0;
  logic [7:0] modelMem [8];
  logic [7:0] bankMem [8];
  logic       tbLastGrant;

  register_bank_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_addr_a(req0_addr_a), .req0_addr_b(req0_addr_b), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_addr_a(req1_addr_a), .req1_addr_b(req1_addr_b), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bank_write_data(bank_write_data), .bank_read_data(bank_read_data),
    .bank_in_select(bank_in_select), .bank_out_select(bank_out_select),
    .bank_in_data(bank_in_data), .bank_out_data(bank_out_data)
  );

  always #5 clock = ~clock;

  // Behavioural register bank: registered write, combinational read while read_data is high.
  always @(posedge clock) begin
    if (bank_write_data) bankMem[bank_in_select] <= bank_in_data;
  end
  assign bank_out_data = bank_read_data ? bankMem[bank_out_select] : 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Every completion pulse is matched against the oldest outstanding expectation.
  always @(negedge clock) begin
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        checkOutput("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic setReq(input logic id, input logic v, input logic [1:0] op,
                        input logic [2:0] a, input logic [2:0] b, input logic [7:0] wd);
    if (!id) begin
      req0_valid = v; req0_op = op; req0_addr_a = a; req0_addr_b = b; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_op = op; req1_addr_a = a; req1_addr_b = b; req1_wdata = wd;
    end
  endtask

  task automatic pushExp(input logic id, input logic [7:0] data, input logic err);
    rsp_t e;
    e.id = id; e.data = data; e.err = err;
    expQ.push_back(e);
  endtask

  task automatic waitReady(input logic id, output logic got);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Issue one op from one requester, queue its expected response, and check its latency.
  task automatic applyStimulus(input logic id, input logic [1:0] op, input logic [2:0] a,
                               input logic [2:0] b, input logic [7:0] wd,
                               input logic [7:0] expData, input logic expErr, input int expLat);
    logic got;
    int   lat;
    @(posedge clock); #1;
    setReq(id, 1'b1, op, a, b, wd);
    waitReady(id, got);
    if (got) begin
      pushExp(id, expData, expErr);
      tbLastGrant = id;
    end
    @(posedge clock); #1;
    setReq(id, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    if (got) begin
      lat = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clock);
        lat++;
        if (rsp_valid === 1'b1) break;
      end
      checkOutput("latency", lat, expLat);
    end
  endtask

  initial begin
    logic got;
    logic gid;
    int   grants, cyc, lastCyc;
    logic [7:0] t;

    reset = 1'b0;
    setReq(1'b0, 1'b1, OP_WRITE, 3'd3, 3'd0, 8'hA5);
    setReq(1'b1, 1'b1, OP_READ, 3'd3, 3'd0, 8'h00);
    tbLastGrant = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_outputs",
      {3'd0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, bank_write_data,
       bank_read_data, bank_in_select, bank_out_select, bank_in_data}, 32'd0);

    // First contest after reset must go to req0; req1 stays pending and follows in the rsp cycle.
    reset = 1'b1;
    #1;
    checkOutput("first_grant", {30'd0, req0_ready, req1_ready}, 32'b10);
    pushExp(1'b0, 8'hA5, 1'b0);
    modelMem[3] = 8'hA5;
    tbLastGrant = 1'b0;
    @(posedge clock); #1;
    setReq(1'b0, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      cyc++;
      if (req1_ready === 1'b1) begin got = 1'b1; break; end
    end
    checkOutput("accept_in_rsp_cycle", cyc, 2);
    if (got) begin
      pushExp(1'b1, 8'hA5, 1'b0);
      tbLastGrant = 1'b1;
    end
    @(posedge clock); #1;
    setReq(1'b1, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("idle_strobes", {30'd0, bank_write_data, bank_read_data}, 32'd0);

    applyStimulus(1'b0, OP_WRITE, 3'd1, 3'd0, 8'h11, 8'h11, 1'b0, 2); modelMem[1] = 8'h11;
    applyStimulus(1'b1, OP_WRITE, 3'd2, 3'd0, 8'h22, 8'h22, 1'b0, 2); modelMem[2] = 8'h22;

    // Both requesters valid continuously: grants must alternate with one accept every two cycles.
    @(posedge clock); #1;
    setReq(1'b0, 1'b1, OP_READ, 3'd3, 3'd0, 8'h00);
    setReq(1'b1, 1'b1, OP_READ, 3'd1, 3'd0, 8'h00);
    grants = 0; cyc = 0; lastCyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      cyc++;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        gid = req1_ready;
        checkOutput("arb_grant", {30'd0, req0_ready, req1_ready}, tbLastGrant ? 32'b10 : 32'b01);
        pushExp(gid, gid ? modelMem[1] : modelMem[3], 1'b0);
        tbLastGrant = gid;
        if (grants > 0) checkOutput("arb_spacing", cyc - lastCyc, 2);
        lastCyc = cyc;
        grants++;
        if (grants == 4) break;
      end
    end
    checkOutput("arb_count", grants, 4);
    @(posedge clock); #1;
    setReq(1'b0, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    setReq(1'b1, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    repeat (3) @(posedge clock);

    // SWAP R1/R2 with req1 waiting: ready stays low until the response cycle.
    @(posedge clock); #1;
    setReq(1'b0, 1'b1, OP_SWAP, 3'd1, 3'd2, 8'h00);
    waitReady(1'b0, got);
    pushExp(1'b0, modelMem[1], 1'b0);
    t = modelMem[1]; modelMem[1] = modelMem[2]; modelMem[2] = t;
    tbLastGrant = 1'b0;
    @(posedge clock); #1;
    setReq(1'b0, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    setReq(1'b1, 1'b1, OP_READ, 3'd1, 3'd0, 8'h00);
    @(negedge clock);
    checkOutput("sw1_strobes", {24'd0, bank_read_data, bank_write_data, bank_out_select, bank_in_select},
                {24'd0, 1'b1, 1'b0, 3'd1, 3'd0});
    checkOutput("busy_ready1", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(negedge clock);
    checkOutput("sw2_strobes", {24'd0, bank_read_data, bank_write_data, bank_out_select, bank_in_select},
                {24'd0, 1'b1, 1'b1, 3'd2, 3'd1});
    checkOutput("busy_ready2", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(negedge clock);
    checkOutput("sw3_strobes", {24'd0, bank_read_data, bank_write_data, bank_out_select, bank_in_select},
                {24'd0, 1'b0, 1'b1, 3'd0, 3'd2});
    checkOutput("sw3_in_data", {24'd0, bank_in_data}, 32'h11);
    checkOutput("busy_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clock);
    checkOutput("swap_rsp_at_4", {31'd0, rsp_valid}, 32'd1);
    checkOutput("held_req_ready", {31'd0, req1_ready}, 32'd1);
    pushExp(1'b1, modelMem[1], 1'b0);
    tbLastGrant = 1'b1;
    @(posedge clock); #1;
    setReq(1'b1, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    repeat (3) @(posedge clock);
    applyStimulus(1'b0, OP_READ, 3'd2, 3'd0, 8'h00, modelMem[2], 1'b0, 2);

    // Reset in the SW2 cycle aborts the swap: no strobes, no response, bank untouched.
    @(posedge clock); #1;
    setReq(1'b1, 1'b1, OP_SWAP, 3'd1, 3'd2, 8'h00);
    waitReady(1'b1, got);
    @(posedge clock); #1;
    setReq(1'b1, 1'b0, OP_READ, 3'd0, 3'd0, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("abort_strobes", {30'd0, bank_write_data, bank_read_data}, 32'd0);
    @(negedge clock);
    checkOutput("abort_outputs",
      {3'd0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, bank_write_data,
       bank_read_data, bank_in_select, bank_out_select, bank_in_data}, 32'd0);
    reset = 1'b1;
    tbLastGrant = 1'b1;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) cyc++;
    end
    checkOutput("abort_no_rsp", cyc, 0);
    applyStimulus(1'b0, OP_READ, 3'd1, 3'd0, 8'h00, modelMem[1], 1'b0, 2);
    applyStimulus(1'b1, OP_READ, 3'd2, 3'd0, 8'h00, modelMem[2], 1'b0, 2);

    applyStimulus(1'b1, OP_SWAP, 3'd3, 3'd3, 8'h00, modelMem[3], 1'b0, 4);
    applyStimulus(1'b0, OP_READ, 3'd3, 3'd0, 8'h00, modelMem[3], 1'b0, 2);

    applyStimulus(1'b0, OP_WRITE, 3'd5, 3'd0, 8'h7F, 8'h7F, 1'b0, 2); modelMem[5] = 8'h7F;
    applyStimulus(1'b1, OP_CLEAR, 3'd5, 3'd0, 8'h00, 8'h00, CLEAR_ERR, 2);
`ifdef REGBANK_CLEAR_EN
    modelMem[5] = 8'h00;
`endif
    applyStimulus(1'b0, OP_READ, 3'd5, 3'd0, 8'h00, modelMem[5], 1'b0, 2);

    for (int k = 0; k < 10; k++) begin
      if (expQ.size() == 0) break;
      @(negedge clock);
    end
    checkOutput("queue_drain", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
